// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional build macro: UART_PARITY_EN adds the PARITY state to the FSM enum.
package uart_pkg;

    // Transmit engine states; PARITY exists only in parity-enabled builds.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;

    // Bit positions inside the status word.
    localparam int BUSY_BIT  = 0;
    localparam int FULL_BIT  = 1;
    localparam int EMPTY_BIT = 2;
    localparam int OVF_BIT   = 3;

    // Default register addresses on the data-memory port.
    localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0100;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0104;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count, no write-to-read bypass.
// Ports: clk, reset (sync, high), push/push_data, pop/pop_data, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX_ADDR stores queue bytes, STAT_ADDR reads status.
// Ports: clk, reset, MemWrite, DataAdr, WriteData in; ReadData, tx, busy out. Macro: UART_PARITY_EN.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic              tx_sel;
    logic              stat_sel;
    logic              tx_wr;
    logic              stat_wr;
    logic              at_cap;
    logic              overflow;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    uart_state_e       state;
    logic [BAUD_W-1:0] baud;
    logic              baud_wrap;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
`ifdef UART_PARITY_EN
    logic              parity_bit;
`endif

    // Only the low byte of a store is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    assign tx_sel   = (DataAdr == TX_ADDR);
    assign stat_sel = (DataAdr == STAT_ADDR);
    assign tx_wr    = MemWrite && tx_sel;
    assign stat_wr  = MemWrite && stat_sel;

    // Capacity is judged on the registered count, so a same-cycle pop
    // never rescues a push into a full FIFO.
    assign at_cap    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_push = tx_wr && !at_cap;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (WriteData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Set beats clear if both happen in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (tx_wr && at_cap) begin
            overflow <= 1'b1;
        end else if (stat_wr) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        ReadData = '0;
        if (stat_sel) begin
            ReadData[BUSY_BIT]  = busy;
            ReadData[FULL_BIT]  = fifo_full;
            ReadData[EMPTY_BIT] = fifo_empty;
            ReadData[OVF_BIT]   = overflow;
        end
    end

    assign busy      = (state != IDLE) || !fifo_empty;
    assign baud_wrap = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    // tx is registered alongside each state change so the line level
    // always matches the state that is being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            baud <= baud_wrap ? '0 : baud + 1'b1;
            unique case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= fifo_head;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
`ifdef UART_PARITY_EN
                        parity_bit <= ^fifo_head;
`endif
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a line monitor decodes frames and checks them
// against bytes queued when the stores were driven. Build with UART_PARITY_EN for parity.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam logic [31:0] TXA   = 32'h0000_0100;
    localparam logic [31:0] STA   = 32'h0000_0104;
`ifdef UART_PARITY_EN
    localparam int          FRAME = 11 * CPB;
`else
    localparam int          FRAME = 10 * CPB;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] sb [$];
    int starts [$];
    bit mon_en = 1'b0;
    bit in_frame = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (TXA),
        .STAT_ADDR    (STA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Called on the negedge where tx is first seen low.
    task automatic rx_frame();
        logic [7:0] data;
        logic       bitv;
        bit         shape_ok;
        logic [7:0] exp;
        in_frame = 1'b1;
        starts.push_back(cyc);
        shape_ok = 1'b1;
        data = '0;
        bitv = 1'b0;
        for (int i = 1; i < CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b0) shape_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (k == 0) bitv = tx;
                else if (tx !== bitv) shape_ok = 1'b0;
                data[b] = bitv;
            end
        end
`ifdef UART_PARITY_EN
        for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== ^data) shape_ok = 1'b0;
        end
`endif
        for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) shape_ok = 1'b0;
        end
        checks++;
        if (!shape_ok) begin
            failures++;
            $display("FAIL frame_shape data=%h got=malformed want=well-formed", data);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%h want=none", data);
        end else begin
            exp = sb.pop_front();
            if (data !== exp) begin
                failures++;
                $display("FAIL frame_data got=%h want=%h", data, exp);
            end
        end
        in_frame = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) rx_frame();
        end
    end

    // One-cycle store; called and returns just after a negedge.
    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || in_frame) begin
            failures++;
            $display("FAIL %s_drain got=%0d pending want=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=tx%b/busy%b want=tx1/busy0", tx, busy);
        end
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_idle got=%0d bad cycles want=0", bad);
        end
        DataAdr = STA;
        #1;
        checks++;
        if (ReadData !== 32'h4) begin
            failures++;
            $display("FAIL reset_stat got=%h want=%h", ReadData, 32'h4);
        end
        DataAdr = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        mon_en = 1'b1;
        sb.push_back(8'h55);
        store(TXA, 32'hFFFF_FF55);
        checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single_push got=busy%b/tx%b want=busy1/tx1", busy, tx);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL single_start got=%b want=0", tx);
        end
        repeat (FRAME - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single_stop_end got=busy%b/tx%b want=busy1/tx1", busy, tx);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_drop got=%b want=0", busy);
        end
        drain("single", 20);
    endtask

    // Byte 0x41 is popped one edge after it lands, so 0x42..0x45 fill the
    // four entries and the sixth store (0x46) is the one that overflows.
    task automatic test_back_to_back();
        int bad;
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(8'(8'h41 + i));
            store(TXA, 32'hDEAD_BE00 | (32'h41 + i));
        end
        DataAdr = STA;
        #1;
        checks++;
        if (ReadData !== 32'hB) begin
            failures++;
            $display("FAIL ovf_stat got=%h want=%h", ReadData, 32'hB);
        end
        @(negedge clk);
        store(STA, 32'h0);
        DataAdr = STA;
        #1;
        checks++;
        if (ReadData !== 32'h3) begin
            failures++;
            $display("FAIL ovf_clear got=%h want=%h", ReadData, 32'h3);
        end
        DataAdr = '0;
        @(negedge clk);
        drain("b2b", 6 * FRAME + 50);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != FRAME + 1) bad++;
        end
        checks++;
        if (starts.size() != 5 || bad != 0) begin
            failures++;
            $display("FAIL b2b_gap got=%0d frames/%0d bad gaps want=5/0", starts.size(), bad);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_decode();
        int bad;
        int nstart;
        nstart = starts.size();
        store(32'h0000_00FC, 32'h0000_005A);
        store(32'h0000_0108, 32'h0000_005A);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL decode_busy got=%b want=0", busy);
        end
        DataAdr = 32'h0000_00FC;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL decode_rd_0fc got=%h want=0", ReadData);
        end
        DataAdr = 32'h0000_0108;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL decode_rd_108 got=%h want=0", ReadData);
        end
        DataAdr = STA;
        #1;
        checks++;
        if (ReadData !== 32'h4) begin
            failures++;
            $display("FAIL decode_stat got=%h want=%h", ReadData, 32'h4);
        end
        DataAdr = '0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || starts.size() != nstart) begin
            failures++;
            $display("FAIL decode_quiet got=%0d low cycles want=0", bad);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic par;
        par = 1'b0;
        sb.push_back(8'h07);
        store(TXA, 32'h0000_0007);
        @(negedge clk);
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 9 * CPB) par = tx;
        end
        checks++;
        if (par !== 1'b1) begin
            failures++;
            $display("FAIL parity_bit got=%b want=1", par);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL parity_len_end got=%b want=1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL parity_len_drop got=%b want=0", busy);
        end
        drain("parity", 20);
    endtask
`endif

    task automatic test_reset_mid();
        int edges;
        logic prev;
        mon_en = 1'b0;
        store(TXA, 32'h0000_00A5);
        @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_data_low got=%b want=0", tx);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=tx%b/busy%b want=tx1/busy0", tx, busy);
        end
        DataAdr = STA;
        #1;
        checks++;
        if (ReadData !== 32'h4) begin
            failures++;
            $display("FAIL mid_reset_stat got=%h want=%h", ReadData, 32'h4);
        end
        DataAdr = '0;
        reset = 1'b0;
        edges = 0;
        prev = tx;
        repeat (60) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        checks++;
        if (edges != 0 || tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_quiet got=%0d edges want=0", edges);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_addr_decode();
`ifdef UART_PARITY_EN
        mon_en = 1'b1;
        test_parity();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
